// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_e;

    // Widest requester vector the generic pick function handles.
    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin search starting just after 'last', wrapping modulo nreq.
    // 'last' itself is the final candidate, so a lone requester is regranted.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   last,
                                                 input int                 nreq);
        logic [IDX_W-1:0] idx;
        logic             found;
        int               c;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            c = (int'(last) + k) % nreq;
            if (k <= nreq && !found && valid[c[IDX_W-1:0]]) begin
                idx   = c[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search over NREQ valid bits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is used.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [IDX_W-1:0]   pick;

    // Widen to the package search width and narrow the result back.
    always_comb begin
        valid_ext            = '0;
        valid_ext[NREQ-1:0]  = valid;
        pick                 = rr_pick(valid_ext, IDX_W'(last), NREQ);
        idx                  = IDW'(pick);
        any                  = |valid;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharing of one FIFO write port; words tagged {owner, data}.
// Latency: first write 1 cycle after valid seen in IDLE; back-to-back grants have no bubble.
// Backpressure: fifo_full stalls the owner (ready=0, no write) without releasing; FIFO_WR_ARBITER_STATS_EN adds grant_cnt.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int DWIDTH    = 8,
    parameter  int MAX_BURST = 4,
    localparam int IDW       = idx_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [DWIDTH-1:0]     req_data [NREQ],
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [IDW+DWIDTH-1:0] fifo_din,
    output logic                  busy
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [15:0]           grant_cnt [NREQ]
`endif
);

    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e       state;
    logic [IDW-1:0]   owner;
    logic [IDW-1:0]   last;
    logic [BW-1:0]    beat_cnt;

    logic [IDW-1:0]   pick_last;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             last_beat;
    logic             rel_now;

    // On a release 'last' becomes the owner in the same cycle, so search from the owner.
    always_comb begin
        pick_last = (state == GRANT) ? owner : last;
    end

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .valid (req_valid),
        .last  (pick_last),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Port muxing: everything quiet in IDLE, owner's channel exposed in GRANT.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        busy       = 1'b0;
        if (state == GRANT) begin
            busy             = 1'b1;
            req_ready[owner] = !fifo_full;
            fifo_wr_en       = req_valid[owner] && !fifo_full;
            fifo_din         = {owner, req_data[owner]};
        end
    end

    // Release when the owner goes quiet or its final permitted beat is written.
    always_comb begin
        last_beat = fifo_wr_en && (beat_cnt == BW'(MAX_BURST - 1));
        rel_now   = !req_valid[owner] || last_beat;
    end

    // Grant FSM with burst accounting; a new grant follows a release with no idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= IDW'(NREQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= GRANT;
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (rel_now) begin
                        last     <= owner;
                        beat_cnt <= '0;
                        if (pick_any) begin
                            owner <= pick_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (fifo_wr_en) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    // Per-requester accepted-beat counters, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else if (fifo_wr_en && grant_cnt[owner] != 16'hFFFF) begin
            grant_cnt[owner] <= grant_cnt[owner] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DWIDTH    = 8;
    localparam int MAX_BURST = 4;
    localparam int QCAP      = 72000;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  req_data [4];
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [9:0]  fifo_din;
    logic        busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] grant_cnt [4];
`endif

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DWIDTH    (DWIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producer queues: a requester is valid while its queue holds words.
    logic [7:0] qbuf [4][0:QCAP-1];
    int         qh [4];
    int         qt [4];

    // Reference model: who holds the port, how many beats it has had, who went last.
    bit         m_busy;
    int         m_owner;
    int         m_last;
    int         m_beats;
    int         m_cnt [4];

    // Write log and last-cycle observations.
    logic [9:0] wdin [0:255];
    int         wcyc [0:255];
    int         wn;
    int         cyc;
    logic       obs_busy;
    logic       obs_wr;
    logic [3:0] obs_rdy;
    logic [9:0] obs_din;

    logic       rst_v;
    logic       full_v;
    int         n_checks;
    int         n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [3:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic push(input int i, input logic [7:0] d);
        if (qt[i] < QCAP) begin
            qbuf[i][qt[i]] = d;
            qt[i]++;
        end
    endtask

    // One clock cycle: drive, check against the model at mid-cycle, advance the model.
    task automatic step();
        logic [3:0] v;
        logic       e_busy;
        logic [3:0] e_rdy;
        logic       e_wr;
        logic [9:0] e_din;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (qh[i] != qt[i]);
            req_data[i]  = req_valid[i] ? qbuf[i][qh[i]] : 8'h00;
        end
        fifo_full = full_v;
        rst       = rst_v;
        #4;
        v      = req_valid;
        e_busy = m_busy;
        e_rdy  = '0;
        e_wr   = 1'b0;
        e_din  = '0;
        if (m_busy) begin
            e_rdy[m_owner] = !full_v;
            e_wr           = v[m_owner] && !full_v;
            e_din          = {2'(m_owner), req_data[m_owner]};
        end
        obs_busy = busy;
        obs_wr   = fifo_wr_en;
        obs_rdy  = req_ready;
        obs_din  = fifo_din;
        chk("busy", 32'(obs_busy), 32'(e_busy));
        chk("req_ready", 32'(obs_rdy), 32'(e_rdy));
        chk("fifo_wr_en", 32'(obs_wr), 32'(e_wr));
        chk("fifo_din", 32'(obs_din), 32'(e_din));
        if (fifo_wr_en && !rst_v && wn < 256) begin
            wdin[wn] = fifo_din;
            wcyc[wn] = cyc;
            wn++;
        end
        if (!rst_v) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) qh[i]++;
            end
        end
        if (rst_v) begin
            m_busy  = 0;
            m_owner = 0;
            m_last  = NREQ - 1;
            m_beats = 0;
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end else begin
            if (e_wr && m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
            if (!m_busy) begin
                if (v != 0) begin
                    m_busy  = 1;
                    m_owner = rr(v, m_last);
                    m_beats = 0;
                end
            end else begin
                if (e_wr) m_beats++;
                if (!v[m_owner] || m_beats == MAX_BURST) begin
                    m_last = m_owner;
                    if (v != 0) begin
                        m_owner = rr(v, m_last);
                        m_beats = 0;
                    end else begin
                        m_busy = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) begin
            qh[i] = 0;
            qt[i] = 0;
        end
        full_v = 1'b0;
        rst_v  = 1'b1;
        step();
        step();
        rst_v = 1'b0;
        wn    = 0;
    endtask

    initial begin
        int start;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        wn        = 0;
        rst_v     = 1'b1;
        full_v    = 1'b0;
        rst       = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i] = '0;
            qh[i]       = 0;
            qt[i]       = 0;
            m_cnt[i]    = 0;
        end
        m_busy  = 0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_beats = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with nothing requesting.
        do_reset();
        step();
        chk("reset_busy", 32'(obs_busy), 32'h0);
        chk("reset_ready", 32'(obs_rdy), 32'h0);
        chk("reset_wr_en", 32'(obs_wr), 32'h0);
        chk("reset_din", 32'(obs_din), 32'h0);

        // Single requester 2: grant after one cycle, 8 back-to-back words across a regrant.
        do_reset();
        for (int k = 0; k < 8; k++) push(2, 8'hA5 + 8'(k));
        start = cyc;
        repeat (12) step();
        chk("s1_count", 32'(wn), 32'd8);
        chk("s1_first_cycle", 32'(wcyc[0]), 32'(start + 1));
        for (int k = 0; k < 8; k++) begin
            chk("s1_din", 32'(wdin[k]), 32'({2'd2, 8'hA5 + 8'(k)}));
            chk("s1_no_gap", 32'(wcyc[k]), 32'(wcyc[0] + k));
        end

        // All four continuously valid: 0,1,2,3 x4 beats, then 0 again, no bubble.
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 5; k++) push(i, 8'(i * 16 + k));
        repeat (24) step();
        chk("s2_count", 32'(wn), 32'd20);
        for (int k = 0; k < 17; k++) begin
            chk("s2_owner", 32'(wdin[k][9:8]), 32'((k / 4) % 4));
            chk("s2_no_gap", 32'(wcyc[k]), 32'(wcyc[0] + k));
        end

        // Owner 1 drops after 2 beats while 3 waits: one empty cycle, then 3 gets a fresh burst.
        do_reset();
        push(1, 8'h11);
        push(1, 8'h12);
        for (int k = 0; k < 5; k++) push(3, 8'h30 + 8'(k));
        repeat (4) step();
        for (int k = 0; k < 3; k++) push(0, 8'h00 + 8'(k));
        repeat (8) step();
        chk("s3_owner1_a", 32'(wdin[0][9:8]), 32'd1);
        chk("s3_owner1_b", 32'(wdin[1][9:8]), 32'd1);
        chk("s3_drop_gap", 32'(wcyc[2]), 32'(wcyc[1] + 2));
        for (int k = 2; k < 6; k++) chk("s3_owner3", 32'(wdin[k][9:8]), 32'd3);
        chk("s3_burst_end", 32'(wdin[6][9:8]), 32'd0);

        // fifo_full for 5 cycles after owner 0's second beat.
        do_reset();
        for (int k = 0; k < 6; k++) push(0, 8'h50 + 8'(k));
        repeat (3) step();
        full_v = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("s4_full_wr_en", 32'(obs_wr), 32'h0);
            chk("s4_full_ready", 32'(obs_rdy), 32'h0);
            chk("s4_full_owner", 32'(obs_din[9:8]), 32'd0);
        end
        full_v = 1'b0;
        repeat (5) step();
        chk("s4_count", 32'(wn), 32'd6);
        chk("s4_stall", 32'(wcyc[2]), 32'(wcyc[1] + 6));
        chk("s4_beat4", 32'(wcyc[3]), 32'(wcyc[2] + 1));
        chk("s4_regrant", 32'(wcyc[4]), 32'(wcyc[3] + 1));

        // Reset during owner 2's third beat; afterwards 0 wins over 2.
        do_reset();
        for (int k = 0; k < 6; k++) push(2, 8'h20 + 8'(k));
        repeat (3) step();
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        push(0, 8'h0A);
        step();
        chk("s5_idle_busy", 32'(obs_busy), 32'h0);
        chk("s5_idle_wr_en", 32'(obs_wr), 32'h0);
        chk("s5_idle_ready", 32'(obs_rdy), 32'h0);
        chk("s5_idle_din", 32'(obs_din), 32'h0);
        step();
        chk("s5_first_owner", 32'(obs_din[9:8]), 32'd0);
        chk("s5_first_wr", 32'(obs_wr), 32'h1);

        // Random traffic, backpressure and occasional reset against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 9) < 3 && (qt[i] - qh[i]) < 6) push(i, 8'($urandom));
            end
            full_v = ($urandom_range(0, 4) == 0);
            rst_v  = ($urandom_range(0, 199) == 0);
            step();
        end
        rst_v  = 1'b0;
        full_v = 1'b0;
`ifdef FIFO_WR_ARBITER_STATS_EN
        for (int i = 0; i < NREQ; i++) chk("rand_grant_cnt", 32'(grant_cnt[i]), 32'(m_cnt[i]));

        // Saturation: 70000 beats from requester 1.
        do_reset();
        for (int k = 0; k < 70000; k++) push(1, 8'(k));
        repeat (70002) step();
        chk("stats_sat_1", 32'(grant_cnt[1]), 32'hFFFF);
        chk("stats_zero_0", 32'(grant_cnt[0]), 32'h0);
        chk("stats_zero_2", 32'(grant_cnt[2]), 32'h0);
        chk("stats_zero_3", 32'(grant_cnt[3]), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one `fifo` instance between NREQ producers (e.g. fetch-refill, debug injector).
- Round-robin arbitration with a burst lock: a granted requester keeps the port until it drops valid or has pushed MAX_BURST beats.
- Each pushed word is tagged with the requester index, so the consumer can demultiplex.
- Sits between the producers' valid/ready interfaces and the FIFO's wr_en/din/full pins.

Parameters:
- NREQ, 4, number of requesters; must be ≥ 2.
- DWIDTH, 8, payload width per requester.
- MAX_BURST, 4, maximum beats per grant; must be ≥ 1.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester valid.
- req_data  in  NREQ x DWIDTH  per-requester payload; unpacked array.
- req_ready  out  NREQ  per-requester accept.
- fifo_full  in  1  full flag from the FIFO.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  IDW+DWIDTH  {owner index, payload}; IDW = $clog2(NREQ).
- busy  out  1  high while in GRANT state.

Behaviour:
- State machine with two states, IDLE and GRANT.
- Registers:
  - state
  - owner (IDW bits)
  - last (IDW bits): last granted index
  - beat_cnt ($clog2(MAX_BURST+1) bits)
- Reset values: state=IDLE, owner=0, last=NREQ-1 (requester 0 has first priority), beat_cnt=0.
- Output reset values: req_ready=0, fifo_wr_en=0, fifo_din=0, busy=0.
- Round-robin pick: the first index with req_valid set, searching last+1, last+2, … with wrap modulo NREQ. The search covers all NREQ indices, including last itself, which is checked last.
- IDLE:
  - All outputs are 0.
  - If any req_valid: next state=GRANT, owner=pick, beat_cnt=0.
  - The grant takes effect the cycle after valid is seen, so IDLE→first write latency is 1 cycle.
- GRANT, combinational outputs:
  - busy=1.
  - req_ready[owner] = !fifo_full; all other ready bits = 0.
  - fifo_wr_en = req_valid[owner] && !fifo_full.
  - fifo_din = {owner, req_data[owner]}, driven whenever in GRANT.
- GRANT, beat accounting:
  - beat = fifo_wr_en.
  - On a beat: beat_cnt++.
- GRANT, release conditions: release this cycle if
  - !req_valid[owner], or
  - a beat occurs with beat_cnt == MAX_BURST-1.
- On release:
  - last=owner.
  - The pick is recomputed with the updated last.
  - If any req_valid (other than an owner that just dropped valid): stay in GRANT with the new owner, beat_cnt=0. There is no bubble between grants.
  - Otherwise go to IDLE.
- A requester that completed MAX_BURST and is the only one valid is regranted next cycle. It loses exactly 0 cycles.
- fifo_full held high: the owner stalls. beat_cnt is not incremented and the grant is held; a full FIFO never forces a release.
- Requester rules:
  - A requester must hold req_valid and req_data stable until ready.
  - If the owner drops valid, that cycle produces no write and is the release cycle.
- rst asserted mid-burst: all state returns to reset values on that edge. Any unwritten beat is not pushed; the requester re-arbitrates after reset.
- A write accepted by the FIFO on the same edge as rst is discarded by the FIFO's own reset. No special handling is required here.

Optional Feature:
- Macro: FIFO_WR_ARBITER_STATS_EN.
- When defined:
  - Adds output grant_cnt, NREQ x 16 bits.
  - Per-requester beat counter, incremented on each accepted beat of that requester.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- When undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_arb_pkg contains:
  - typedef enum logic {IDLE, GRANT} arb_state_e.
  - Function rr_pick(valid vector, last) returning the index.
  - localparam-style helper for IDW.
- One natural sub-module: rr_picker. It is the combinational round-robin search, parameterised by NREQ, with inputs valid and last and outputs idx and any.
- State, burst counting and muxing stay in fifo_wr_arbiter.

Test Plan:
- Single requester, post-reset:
  - Stimulus: req_valid=4'b0100 with data 8'hA5..A8; fifo_full=0.
  - Required: grant 1 cycle later with owner=2; 4 consecutive writes fifo_din = {2'd2, 8'hA5}…{2'd2, 8'hA8}.
  - Required: re-grant without a gap while valid stays high.
- All four requesters continuously valid, MAX_BURST=4:
  - Required: owners 0,1,2,3,0 in turn, 4 beats each.
  - Required: 16 consecutive fifo_wr_en cycles with no bubble.
- Owner 1 drops valid after 2 beats while requester 3 is valid:
  - Required: the drop cycle has no write; the next cycle owner=3 with beat_cnt reset to 0.
- fifo_full raised for 5 cycles mid-burst (beat 2 of owner 0):
  - Required: fifo_wr_en=0 and req_ready=0 during those cycles; owner stays 0.
  - Required: beats 3–4 complete after full falls, then release.
- rst pulsed during beat 3 of owner 2:
  - Required: the next cycle is IDLE with all outputs 0 and last=3.
  - Required: with requesters 0 and 2 valid, 0 is granted first.
- With FIFO_WR_ARBITER_STATS_EN defined: 70000 beats from requester 1 → grant_cnt[1] = 16'hFFFF (saturated); the others are 0.
